// File: rtl/mem_byte_sequencer.sv
// Serialises byte/half/word loads and stores onto a byte-wide memory port.
// Latency N+1 cycles (N = bytes); req_ready only in IDLE, req_valid ignored while busy.
module mem_byte_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_write_data,
    output logic              mem_write_enable,
    input  logic [7:0]        mem_read_data
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic                         accept;
    logic                         wr_q;
    logic [1:0]                   last_idx_q;
    logic [1:0]                   idx_q;
    logic [ADDR_W-1:0]            base_q;
    logic [NBYTES-1:0][7:0]       wdata_q;
    logic [NBYTES-1:0][7:0]       rbuf_q;
    logic                         err_q;
    logic                         size_illegal;
    logic [1:0]                   size_last_idx;

    assign accept       = req_valid & req_ready;
    assign size_illegal = (req_size == 2'b11);

    always_comb begin
        case (req_size)
            2'b00:   size_last_idx = 2'd0;
            2'b01:   size_last_idx = 2'd1;
            default: size_last_idx = 2'd3;
        endcase
    end

    always_comb begin
        state_nxt        = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = size_illegal ? RESP : XFER;
                end
            end
            XFER: begin
                // Address arithmetic wraps at the top of the byte space.
                mem_address = base_q + {{(ADDR_W-2){1'b0}}, idx_q};
                if (wr_q) begin
                    mem_write_data   = wdata_q[idx_q];
                    mem_write_enable = 1'b1;
                end
                if (idx_q == last_idx_q) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            last_idx_q <= 2'd0;
            idx_q      <= 2'd0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            wr_q       <= req_write;
            last_idx_q <= size_last_idx;
            idx_q      <= 2'd0;
            base_q     <= req_addr;
            wdata_q    <= req_wdata;
            rbuf_q     <= '0;
            err_q      <= size_illegal;
        end else if (state == XFER) begin
            if (!wr_q) begin
                rbuf_q[idx_q] <= mem_read_data;
            end
            idx_q <= idx_q + 2'd1;
        end
    end

    // Stores never touch the read buffer, so it reads back as zero for them.
    assign resp_rdata = rbuf_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Randomised and directed bench for mem_byte_sequencer against a byte-array reference model.
module tb_mem_byte_sequencer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_write_data;
    logic              mem_write_enable;
    logic [7:0]        mem_read_data;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int total = 0;
    int bad   = 0;
    logic [31:0] got;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    function automatic logic [7:0] init_byte(input int i);
        if (i >= 32'h40 && i < 32'h44) return 8'h00;
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    assign mem_read_data = mem[mem_address];

    // Byte memory owned by one process: preload, then accept strobed writes.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_write_enable) mem[mem_address] = mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge with the sequencer idle; returns at a falling edge.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic [15:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
        int n;
        int lat;
        int we_cnt;
        logic [31:0] exp_rd;
        logic exp_err;
        logic [15:0] ba;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (sz == 2'd3);
        exp_rd = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + 16'(i);
            if (w) ref_mem[ba] = d[8*i +: 8];
            else exp_rd[8*i +: 8] = ref_mem[ba];
        end
        check("idle_ready", 32'(req_ready), 1);
        check("idle_addr", 32'(mem_address), 0);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = 0; we_cnt = 0; rd = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_write_enable) we_cnt++;
            if (resp_valid) begin
                lat = c;
                rd = resp_rdata;
                check("resp_rdata", resp_rdata, exp_rd);
                check("resp_err", 32'(resp_err), 32'(exp_err));
            end
        end
        check("latency", lat, n + 1);
        check("we_cycles", we_cnt, (w && !exp_err) ? n : 0);
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 0);
        check("ready_again", 32'(req_ready), 1);
        check("rdata_hold", resp_rdata, exp_rd);
        check("err_hold", 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < 4; i++) begin
            ba = a + 16'(i);
            check("mem_byte", 32'(mem[ba]), 32'(ref_mem[ba]));
        end
    endtask

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] expb;
        int rv_first, rv_second, rv_extra, we_cnt, we_c;
        bit rv_seen;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_addr = '0; req_wdata = '0;
        #3;
        check("rst_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_wdat", 32'(mem_write_data), 0);
        check("rst_we", 32'(mem_write_enable), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Word store then loads of the same bytes.
        run_req(1'b1, 2'b10, 16'h0010, 32'hDDCCBBAA, got);
        expb = 32'hDDCCBBAA;
        for (int i = 0; i < 4; i++) check("st_word_byte", 32'(mem[16'h10 + 16'(i)]), 32'(expb[8*i +: 8]));
        run_req(1'b0, 2'b10, 16'h0010, 32'h0, got);
        check("ld_word", got, 32'hDDCCBBAA);
        run_req(1'b0, 2'b00, 16'h0012, 32'h0, got);
        check("ld_byte", got, 32'h000000CC);

        // Half store wrapping past the top of memory.
        run_req(1'b1, 2'b01, 16'hFFFF, 32'h0000BEEF, got);
        check("wrap_lo", 32'(mem[16'hFFFF]), 32'hEF);
        check("wrap_hi", 32'(mem[16'h0000]), 32'hBE);
        run_req(1'b0, 2'b01, 16'hFFFF, 32'h0, got);
        check("ld_wrap", got, 32'h0000BEEF);

        run_req(1'b1, 2'b11, 16'h0020, 32'h12345678, got);

        // Reset two cycles into a word store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 16'h0040; req_wdata = 32'h44332211;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_we", 32'(mem_write_enable), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_addr", 32'(mem_address), 0);
        check("abort_err", 32'(resp_err), 0);
        rv_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (resp_valid) rv_seen = 1'b1;
        end
        check("abort_no_resp", 32'(rv_seen), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[16'h40] = 8'h11; ref_mem[16'h41] = 8'h22;
        expb = 32'h00002211;
        for (int i = 0; i < 4; i++) check("abort_mem", 32'(mem[16'h40 + 16'(i)]), 32'(expb[8*i +: 8]));

        // req_valid held high across a busy word load, fields swapped to a byte store.
        run_req(1'b0, 2'b00, 16'h0041, 32'h0, got);
        check("post_rst_ld", got, 32'h00000022);
        check("b2b_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_addr = 16'h0010; req_wdata = 32'h0;
        @(posedge clk);
        rv_first = 0; rv_second = 0; rv_extra = 0; we_cnt = 0; we_c = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write = 1'b1; req_size = 2'b00; req_addr = 16'h0030; req_wdata = 32'h0000005A;
            end
            if (mem_write_enable) begin
                we_cnt++;
                we_c = c;
            end
            if (resp_valid) begin
                if (rv_first == 0) begin
                    rv_first = c;
                    check("b2b_ld_rdata", resp_rdata, 32'hDDCCBBAA);
                end else if (rv_second == 0) begin
                    rv_second = c;
                    check("b2b_st_rdata", resp_rdata, 0);
                end else begin
                    rv_extra++;
                end
            end
            if (c == 6) check("b2b_ready_c6", 32'(req_ready), 1);
            if (c == 7) req_valid = 1'b0;
        end
        ref_mem[16'h30] = 8'h5A;
        check("b2b_first", rv_first, 5);
        check("b2b_second", rv_second, 8);
        check("b2b_extra", rv_extra, 0);
        check("b2b_we_cnt", we_cnt, 1);
        check("b2b_we_cycle", we_c, 7);
        check("b2b_mem", 32'(mem[16'h30]), 32'h5A);

        for (int t = 0; t < 250; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                             : 16'($urandom_range(0, 255));
            d  = $urandom;
            run_req(w, sz, a, d, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
